m_mxn_sw: RTL and testbench
===========================

# m_mxn_sw

Parametrised N-way, W-bit registered selector with a break-before-make switching protocol. Changing channels inserts a programmable run of forced-zero, invalid output cycles, so downstream logic never sees a direct old-to-new transition. It generalises the 2:1 selector cell for gated-clock-enable and control-signal steering in the std-cell layer. It uses a single clock domain and adds a handshaked select request, an out-of-range check and a status output.

## Interface
- N, 4: number of input channels, ≥2.
- W, 1: bits per channel.
- GAP, 2: forced-zero cycles per switch, ≥1.
- RST_SEL, 0: channel selected out of reset, <N.
- SW (localparam): $clog2(N).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- sel_req_vld  in  1  select request valid.
- sel_req_idx  in  SW  requested channel.
- sel_req_rdy  out  1  request accepted when vld&rdy at a rising edge.
- sel_err  out  1  one-cycle pulse: accepted idx ≥ N.
- cur_sel  out  SW  committed channel.
- switching  out  1  high during BREAK.
- out_data  out  W  registered selected data.
- out_vld  out  1  out_data is live channel data.

## Operation
- States: RUN and BREAK. Reset enters RUN.
- BREAK counter width: $clog2(GAP+1).
- sel_req_rdy = (state==RUN). It is combinational, with no dependency on sel_req_vld.
- In RUN, an accepted request falls into one of three cases:
  - idx == cur_sel: no-op, stay in RUN, output undisturbed.
  - idx ≥ N: sel_err pulses in the next cycle. cur_sel is unchanged and the state stays RUN. This case is only reachable when N is not a power of 2.
  - Otherwise: latch pend_sel=idx, load cnt=GAP-1, go to BREAK.
- In BREAK: requests are not accepted and switching=1. cnt decrements each cycle. At cnt==0, cur_sel<=pend_sel and the state returns to RUN.
- Output register update rule:
  - out_data <= in_data[sel_next] and out_vld <= 1 when state_next==RUN and no switch is accepted this cycle.
  - Otherwise out_data <= 0 and out_vld <= 0.
  - sel_next is the cur_sel value after this edge.
- The data path never selects an index ≥ N.
- Reset values:
  - state=RUN, cur_sel=RST_SEL, cnt=0, pend_sel=RST_SEL.
  - out_data=0, out_vld=0, sel_err=0.
  - switching=0. sel_req_rdy=1 after reset deasserts.
- Reset asserted mid-BREAK aborts the switch; the reset values apply at the next edge.

## Timing
- Steady-state latency: in_data[cur_sel] sampled at edge e appears on out_data after edge e.
- A switch accepted at the edge ending cycle k proceeds as follows:
  - Cycle k output is old-channel data sampled in k-1.
  - Cycles k+1 … k+GAP: out_data=0, out_vld=0, switching=1, rdy=0.
  - cur_sel shows the new value from cycle k+GAP+1.
  - out_data shows new-channel data, sampled in cycle k+GAP, from cycle k+GAP+1.
- Exactly GAP invalid cycles occur per real switch. Zero invalid cycles occur for a no-op request or an error request.
- The earliest next accept is at the edge ending cycle k+GAP+1.
- First cycle after reset release: out_vld=0. From the second cycle: out_vld=1 with RST_SEL data.
- A request held through BREAK is accepted in the first RUN cycle. Back-to-back switches therefore give GAP invalid cycles, one valid cycle, then GAP invalid cycles.
- With GAP=1, the BREAK counter is loaded with 0 and BREAK lasts exactly one cycle.

## Test plan
- Reset, N=4, W=8, RST_SEL=2, in_data={8'h44,8'h33,8'h22,8'h11} → cycle 1 out_vld=0, out_data=0. Cycle 2 out_data=8'h33, out_vld=1, cur_sel=2.
- Switch 2→0 accepted at cycle 10, GAP=2 → cycles 11–12 out 0/invalid, switching=1, rdy=0. Cycle 13 out_data=8'h11, cur_sel=0.
- Request idx==cur_sel → accepted, no invalid cycles, out_data continuous, switching stays 0.
- N=3, request idx=3 → sel_err pulses once, cur_sel unchanged, out_vld stays 1.
- sel_req_vld held high with alternating idx 1,3 → pattern of GAP invalid, 1 valid, GAP invalid; rdy low throughout each BREAK.
- rst asserted in the first BREAK cycle of a 0→3 switch → next cycle cur_sel=RST_SEL, out_vld=0. RST_SEL data follows one cycle after release; channel 3 never appears.

Source files
------------

// File: rtl/m_mxn_sw.sv
// m_mxn_sw: N-way, W-bit registered selector with break-before-make switching.
// A channel change forces GAP zero/invalid output cycles between the old and
// new channel so downstream logic never sees a direct old-to-new transition.
module m_mxn_sw #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 1,
    parameter int unsigned GAP     = 2,
    parameter int unsigned RST_SEL = 0,
    localparam int unsigned SW     = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic             sel_req_vld,
    input  logic [SW-1:0]    sel_req_idx,
    output logic             sel_req_rdy,
    output logic             sel_err,
    output logic [SW-1:0]    cur_sel,
    output logic             switching,
    output logic [W-1:0]     out_data,
    output logic             out_vld
);

    localparam int unsigned CW    = $clog2(GAP + 1);
    localparam logic [SW:0] N_EXT = (SW + 1)'(N);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BREAK = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic [SW-1:0]  pend_sel;
    logic [SW-1:0]  pend_next;
    logic [SW-1:0]  cur_next;
    logic [W-1:0]   data_next;
    logic           vld_next;
    logic           err_next;
    logic           sw_acc;

    // Requests are only taken while RUN; BREAK is visible as switching.
    assign sel_req_rdy = (state == ST_RUN);
    assign switching   = (state == ST_BREAK);

    // Next-state: request classification in RUN, gap countdown in BREAK.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pend_next  = pend_sel;
        cur_next   = cur_sel;
        err_next   = 1'b0;
        sw_acc     = 1'b0;
        case (state)
            ST_RUN: begin
                if (sel_req_vld) begin
                    if ({1'b0, sel_req_idx} >= N_EXT) begin
                        err_next = 1'b1;
                    end else if (sel_req_idx != cur_sel) begin
                        sw_acc     = 1'b1;
                        pend_next  = sel_req_idx;
                        cnt_next   = CW'(GAP - 1);
                        state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (cnt == '0) begin
                    cur_next   = pend_sel;
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Output mux: only committed, in-range channels are ever routed; zero otherwise.
    always_comb begin
        data_next = '0;
        vld_next  = 1'b0;
        if (state_next == ST_RUN && !sw_acc) begin
            vld_next = 1'b1;
            for (int i = 0; i < int'(N); i++) begin
                if (cur_next == SW'(i)) begin
                    data_next = in_data[i*W +: W];
                end
            end
        end
    end

    // State, selection and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            cnt      <= '0;
            pend_sel <= SW'(RST_SEL);
            cur_sel  <= SW'(RST_SEL);
            out_data <= '0;
            out_vld  <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            pend_sel <= pend_next;
            cur_sel  <= cur_next;
            out_data <= data_next;
            out_vld  <= vld_next;
            sel_err  <= err_next;
        end
    end

endmodule

// File: tb/tb_m_mxn_sw.sv
// Bench for m_mxn_sw: two instances (N=4/GAP=2/RST_SEL=2 and N=3/GAP=1/RST_SEL=0)
// compared every cycle against a cycle-index timing model of the switch protocol.
module tb_m_mxn_sw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        v4;
    logic [1:0]  i4;
    logic [31:0] d4;
    logic        rdy4, err4, sw4, ov4;
    logic [1:0]  cs4;
    logic [7:0]  od4;

    logic        v3;
    logic [1:0]  i3;
    logic [23:0] d3;
    logic        rdy3, err3, sw3, ov3;
    logic [1:0]  cs3;
    logic [7:0]  od3;

    m_mxn_sw #(.N(4), .W(8), .GAP(2), .RST_SEL(2)) dut4 (
        .clk(clk), .rst(rst), .in_data(d4),
        .sel_req_vld(v4), .sel_req_idx(i4), .sel_req_rdy(rdy4),
        .sel_err(err4), .cur_sel(cs4), .switching(sw4),
        .out_data(od4), .out_vld(ov4)
    );

    m_mxn_sw #(.N(3), .W(8), .GAP(1), .RST_SEL(0)) dut3 (
        .clk(clk), .rst(rst), .in_data(d3),
        .sel_req_vld(v3), .sel_req_idx(i3), .sel_req_rdy(rdy3),
        .sel_err(err3), .cur_sel(cs3), .switching(sw3),
        .out_data(od3), .out_vld(ov3)
    );

    // Model state: committed channel, pending channel, and the cycle index
    // at which the last real switch was accepted (far past when none).
    typedef struct {
        int sel;
        int pend;
        int acc;
        int err;
        int od;
        int ov;
        int busy;
    } mdl_t;

    mdl_t m4, m3;
    int   cyc;
    int   checks;
    int   errors;

    // A switch accepted in cycle a blocks cycles a+1 .. a+gap.
    function automatic bit mdl_rdy(mdl_t m, int c, int gap);
        return !(m.acc < c && c <= m.acc + gap);
    endfunction

    // Outcome of the edge that ends cycle c, given that cycle's inputs.
    function automatic mdl_t mdl_next(mdl_t m, int c, bit r, bit vld, int idx,
                                      logic [31:0] data, int n, int gap, int rst_sel);
        mdl_t q;
        bit   rdy;
        q = m;
        if (r) begin
            q.sel  = rst_sel;
            q.pend = rst_sel;
            q.acc  = -1000;
            q.err  = 0;
            q.od   = 0;
            q.ov   = 0;
            q.busy = 0;
            return q;
        end
        rdy   = mdl_rdy(m, c, gap);
        q.err = 0;
        if (c == m.acc + gap) q.sel = m.pend;
        if (rdy && vld) begin
            if (idx >= n) begin
                q.err = 1;
            end else if (idx != q.sel) begin
                q.pend = idx;
                q.acc  = c;
            end
        end
        q.busy = (q.acc <= c && c < q.acc + gap) ? 1 : 0;
        if (q.busy != 0) begin
            q.od = 0;
            q.ov = 0;
        end else begin
            q.od = int'(data[q.sel*8 +: 8]);
            q.ov = 1;
        end
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock, then compare every output of both instances.
    task automatic step();
        m4 = mdl_next(m4, cyc, rst, v4, int'(i4), d4, 4, 2, 2);
        m3 = mdl_next(m3, cyc, rst, v3, int'(i3), {8'h00, d3}, 3, 1, 0);
        @(posedge clk);
        #1;
        cyc++;
        chk("n4_out_data",  32'(od4),  32'(m4.od));
        chk("n4_out_vld",   32'(ov4),  32'(m4.ov));
        chk("n4_cur_sel",   32'(cs4),  32'(m4.sel));
        chk("n4_switching", 32'(sw4),  32'(m4.busy));
        chk("n4_rdy",       32'(rdy4), 32'(m4.busy == 0));
        chk("n4_sel_err",   32'(err4), 32'(m4.err));
        chk("n3_out_data",  32'(od3),  32'(m3.od));
        chk("n3_out_vld",   32'(ov3),  32'(m3.ov));
        chk("n3_cur_sel",   32'(cs3),  32'(m3.sel));
        chk("n3_switching", 32'(sw3),  32'(m3.busy));
        chk("n3_rdy",       32'(rdy3), 32'(m3.busy == 0));
        chk("n3_sel_err",   32'(err3), 32'(m3.err));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        m4 = '{sel: 2, pend: 2, acc: -1000, err: 0, od: 0, ov: 0, busy: 0};
        m3 = '{sel: 0, pend: 0, acc: -1000, err: 0, od: 0, ov: 0, busy: 0};
        rst = 1'b1;
        v4  = 1'b0; i4 = 2'd0; d4 = 32'h44332211;
        v3  = 1'b0; i3 = 2'd0; d3 = 24'h332211;

        // Reset, then first cycle invalid, then RST_SEL data.
        step();
        step();
        rst = 1'b0;
        step();
        repeat (5) step();

        // Real switch 2 -> 0.
        v4 = 1'b1; i4 = 2'd0;
        step();
        v4 = 1'b0;
        repeat (4) step();

        // No-op request to the current channel.
        v4 = 1'b1; i4 = 2'd0;
        step();
        v4 = 1'b0;
        repeat (2) step();

        // Out-of-range request on the N=3 instance.
        v3 = 1'b1; i3 = 2'd3;
        step();
        v3 = 1'b0;
        repeat (2) step();

        // Request held high through BREAK with alternating targets 1,3.
        v4 = 1'b1; i4 = 2'd1;
        for (int k = 0; k < 14; k++) begin
            bit taken;
            taken = mdl_rdy(m4, cyc, 2);
            step();
            if (taken) i4 = (i4 == 2'd1) ? 2'd3 : 2'd1;
        end
        v4 = 1'b0;
        repeat (3) step();

        // Move to channel 0, then reset in the first BREAK cycle of 0 -> 3.
        v4 = 1'b1; i4 = 2'd0;
        step();
        v4 = 1'b0;
        repeat (4) step();
        v4 = 1'b1; i4 = 2'd3;
        step();
        v4 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (6) step();

        // Randomised traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            v4  = ($urandom_range(0, 2) == 0);
            i4  = 2'($urandom);
            d4  = $urandom;
            v3  = ($urandom_range(0, 2) == 0);
            i3  = 2'($urandom_range(0, 3));
            d3  = 24'($urandom);
            step();
        end
        rst = 1'b0; v4 = 1'b0; v3 = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
